// File: rtl/hnf_pocq_arb_pkg.sv
// hnf_pocq_arb_pkg: flit types, FSM state and grant-select enums shared by the pocq arbiter
package hnf_pocq_arb_pkg;
  typedef struct packed {
    logic [43:0] addr;
    logic [6:0]  opcode;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
  } reqflit_t;
  typedef struct packed {
    logic [4:0] opcode;
    logic [6:0] srcid;
    logic [7:0] txnid;
  } rspflit_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} arb_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_REQ, GNT_RNP, GNT_RSP} gnt_e;
endpackage

// File: rtl/hnf_rr_arb2.sv
// hnf_rr_arb2: 2-way round-robin arbiter (a=rnp, b=req); ports clk_i, rst_i, a_i, b_i -> ga_o, gb_o
module hnf_rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_i,
  input  logic b_i,
  output logic ga_o,
  output logic gb_o
);
  logic ptr_q, ptr_d;
  assign ga_o  = a_i && (!b_i || !ptr_q);
  assign gb_o  = b_i && (!a_i || ptr_q);
  // pointer only moves when both sides contend
  assign ptr_d = (a_i && b_i) ? !ptr_q : ptr_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/hnf_pocq_arb.sv
// hnf_pocq_arb: pocq front-end arbiter (rsp > rr(rnp,req)), occupancy tracking, flush FSM; optional perf counters via POCQ_ARB_PERF_EN
module hnf_pocq_arb
  import hnf_pocq_arb_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  input  reqflit_t         req_flit_i,
  output logic             req_ready_o,
  input  logic             rnp_valid_i,
  input  reqflit_t         rnp_flit_i,
  output logic             rnp_ready_o,
  input  logic             rsp_valid_i,
  input  rspflit_t         rsp_flit_i,
  output logic             rsp_ready_o,
  output logic             req_entry_en_o,
  output reqflit_t         req_entry_o,
  output logic             read_no_snp_v_o,
  output reqflit_t         read_no_snp_o,
  output logic             rsp_entry_en_o,
  output rspflit_t         rsp_entry_o,
  input  logic             pocq_is_empty_i,
  input  logic             flush_req_i,
  input  logic             resume_i,
  output logic             flush_done_o,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             err_underflow_o
`ifdef POCQ_ARB_PERF_EN
  ,
  output logic [31:0]      perf_req_full_stall_o,
  output logic [31:0]      perf_req_arb_stall_o,
  output logic [31:0]      perf_grants_o
`endif
);
  arb_state_e state_q, state_d;
  gnt_e gnt;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic req_en_q, rnp_en_q, rsp_en_q, flush_done_q, err_q;
  reqflit_t req_entry_q, rnp_entry_q;
  rspflit_t rsp_entry_q;
  logic occ_zero, occ_full, serve, pend, rnp_arb, req_arb;
  assign occ_zero    = occ_q == '0;
  assign occ_full    = occ_q == OCC_W'(DEPTH);
  assign serve       = state_q != HALT;
  assign pend        = req_en_q || rnp_en_q || rsp_en_q;
  assign rsp_ready_o = rsp_valid_i && serve;
  assign rnp_arb     = rnp_valid_i && serve && !rsp_valid_i;
  // flush_req blocks a same-cycle request
  assign req_arb     = req_valid_i && state_q == RUN && !flush_req_i && !occ_full && !rsp_valid_i;
  hnf_rr_arb2 u_rr (
    .clk_i (clock_i),
    .rst_i (reset_i),
    .a_i   (rnp_arb),
    .b_i   (req_arb),
    .ga_o  (rnp_ready_o),
    .gb_o  (req_ready_o)
  );
  always_comb begin
    gnt = rsp_ready_o ? GNT_RSP : rnp_ready_o ? GNT_RNP : req_ready_o ? GNT_REQ : GNT_NONE;
    occ_d = (gnt == GNT_REQ) ? occ_q + OCC_W'(1) :
            (gnt == GNT_RSP && !occ_zero) ? occ_q - OCC_W'(1) : occ_q;
    state_d = (state_q == RUN && flush_req_i) ? DRAIN :
              (state_q == DRAIN && occ_zero && pocq_is_empty_i && !pend) ? HALT :
              (state_q == HALT && resume_i) ? RUN : state_q;
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q      <= RUN;
      occ_q        <= '0;
      req_en_q     <= 1'b0;
      rnp_en_q     <= 1'b0;
      rsp_en_q     <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
      req_entry_q  <= '0;
      rnp_entry_q  <= '0;
      rsp_entry_q  <= '0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      req_en_q     <= gnt == GNT_REQ;
      // replace/release at zero occupancy is swallowed and flagged
      rnp_en_q     <= gnt == GNT_RNP && !occ_zero;
      rsp_en_q     <= gnt == GNT_RSP && !occ_zero;
      flush_done_q <= state_d == HALT;
      err_q        <= err_q || ((gnt == GNT_RSP || gnt == GNT_RNP) && occ_zero);
      req_entry_q  <= (gnt == GNT_REQ) ? req_flit_i : req_entry_q;
      rnp_entry_q  <= (gnt == GNT_RNP && !occ_zero) ? rnp_flit_i : rnp_entry_q;
      rsp_entry_q  <= (gnt == GNT_RSP && !occ_zero) ? rsp_flit_i : rsp_entry_q;
    end
  assign req_entry_en_o  = req_en_q;
  assign req_entry_o     = req_entry_q;
  assign read_no_snp_v_o = rnp_en_q;
  assign read_no_snp_o   = rnp_entry_q;
  assign rsp_entry_en_o  = rsp_en_q;
  assign rsp_entry_o     = rsp_entry_q;
  assign flush_done_o    = flush_done_q;
  assign occupancy_o     = occ_q;
  assign err_underflow_o = err_q;
`ifdef POCQ_ARB_PERF_EN
  logic [31:0] pf_full_q, pf_arb_q, pf_gnt_q;
  logic inc_full, inc_arb, inc_gnt;
  assign inc_full = req_valid_i && occ_full;
  assign inc_arb  = req_valid_i && !req_ready_o && !occ_full;
  assign inc_gnt  = gnt != GNT_NONE;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      pf_full_q <= '0;
      pf_arb_q  <= '0;
      pf_gnt_q  <= '0;
    end else begin
      pf_full_q <= pf_full_q + {31'b0, inc_full && pf_full_q != '1};
      pf_arb_q  <= pf_arb_q + {31'b0, inc_arb && pf_arb_q != '1};
      pf_gnt_q  <= pf_gnt_q + {31'b0, inc_gnt && pf_gnt_q != '1};
    end
  assign perf_req_full_stall_o = pf_full_q;
  assign perf_req_arb_stall_o  = pf_arb_q;
  assign perf_grants_o         = pf_gnt_q;
`endif
endmodule

// File: tb/tb_hnf_pocq_arb.sv
// tb_hnf_pocq_arb: directed self-checking bench for hnf_pocq_arb
module tb_hnf_pocq_arb;
  import hnf_pocq_arb_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 0, rnp_valid = 0, rsp_valid = 0;
  reqflit_t req_flit = '0, rnp_flit = '0;
  rspflit_t rsp_flit = '0;
  logic req_ready, rnp_ready, rsp_ready;
  logic req_entry_en, read_no_snp_v, rsp_entry_en;
  reqflit_t req_entry, read_no_snp;
  rspflit_t rsp_entry;
  logic pocq_is_empty = 0, flush_req = 0, resume = 0, flush_done, err_underflow;
  logic [4:0] occupancy;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hnf_pocq_arb dut (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_flit_i(req_flit), .req_ready_o(req_ready),
    .rnp_valid_i(rnp_valid), .rnp_flit_i(rnp_flit), .rnp_ready_o(rnp_ready),
    .rsp_valid_i(rsp_valid), .rsp_flit_i(rsp_flit), .rsp_ready_o(rsp_ready),
    .req_entry_en_o(req_entry_en), .req_entry_o(req_entry),
    .read_no_snp_v_o(read_no_snp_v), .read_no_snp_o(read_no_snp),
    .rsp_entry_en_o(rsp_entry_en), .rsp_entry_o(rsp_entry),
    .pocq_is_empty_i(pocq_is_empty), .flush_req_i(flush_req), .resume_i(resume),
    .flush_done_o(flush_done), .occupancy_o(occupancy), .err_underflow_o(err_underflow)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_occ", occupancy, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_reqen", req_entry_en, 0);
    chk("rst_rnpv", read_no_snp_v, 0);
    chk("rst_rspen", rsp_entry_en, 0);
    chk("rst_reqdata", req_entry, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1;
      req_flit = '{addr: 44'(i * 64), opcode: 7'h04, srcid: 7'h01, txnid: 8'(i)};
      #1 chk("fill_ready", req_ready, 1);
      tick();
      chk("fill_en", req_entry_en, 1);
      chk("fill_txn", req_entry.txnid, i);
      chk("fill_occ", occupancy, i + 1);
    end
    #1 chk("full_ready", req_ready, 0);
    tick();
    chk("full_en", req_entry_en, 0);
    chk("full_occ", occupancy, 16);
    rsp_valid = 1;
    rsp_flit = '{opcode: 5'h02, srcid: 7'h03, txnid: 8'hA0};
    #1 chk("fr_rsp_ready", rsp_ready, 1);
    chk("fr_req_ready", req_ready, 0);
    tick();
    chk("fr_occ15", occupancy, 15);
    chk("fr_rsp_en", rsp_entry_en, 1);
    chk("fr_rsp_txn", rsp_entry.txnid, 8'hA0);
    rsp_valid = 0;
    #1 chk("fr_req_ready2", req_ready, 1);
    tick();
    chk("fr_occ16", occupancy, 16);
    chk("fr_req_en", req_entry_en, 1);
    req_valid = 0;
    rsp_valid = 1;
    repeat (11) tick();
    rsp_valid = 0;
    chk("pre_cont_occ", occupancy, 5);
    req_valid = 1; rnp_valid = 1; rsp_valid = 1;
    rnp_flit = '{addr: 44'h123, opcode: 7'h04, srcid: 7'h02, txnid: 8'h55};
    #1 chk("c1_rsp", rsp_ready, 1);
    chk("c1_rnp", rnp_ready, 0);
    chk("c1_req", req_ready, 0);
    tick();
    chk("c1_occ", occupancy, 4);
    rsp_valid = 0;
    #1 chk("c2_rnp", rnp_ready, 1);
    chk("c2_req", req_ready, 0);
    tick();
    chk("c2_occ", occupancy, 4);
    chk("c2_rnpv", read_no_snp_v, 1);
    chk("c2_rnp_txn", read_no_snp.txnid, 8'h55);
    #1 chk("c3_req", req_ready, 1);
    chk("c3_rnp", rnp_ready, 0);
    tick();
    chk("c3_occ", occupancy, 5);
    chk("c3_reqen", req_entry_en, 1);
    chk("c3_rnpv", read_no_snp_v, 0);
    req_valid = 0; rnp_valid = 0;
    rsp_valid = 1;
    repeat (2) tick();
    rsp_valid = 0;
    chk("fl_occ3", occupancy, 3);
    flush_req = 1; req_valid = 1;
    #1 chk("fl_req_same", req_ready, 0);
    tick();
    flush_req = 0;
    #1 chk("fl_req_drain", req_ready, 0);
    rsp_valid = 1;
    repeat (3) tick();
    rsp_valid = 0;
    chk("fl_occ0", occupancy, 0);
    chk("fl_done0", flush_done, 0);
    pocq_is_empty = 1;
    tick();
    chk("fl_done_pend", flush_done, 0);
    tick();
    chk("fl_done1", flush_done, 1);
    rnp_valid = 1;
    #1 chk("halt_rnp", rnp_ready, 0);
    chk("halt_req", req_ready, 0);
    rnp_valid = 0;
    resume = 1;
    tick();
    resume = 0;
    chk("res_done0", flush_done, 0);
    chk("res_req", req_ready, 1);
    tick();
    req_valid = 0;
    chk("res_occ", occupancy, 1);
    rsp_valid = 1;
    tick();
    chk("uf_pre_err", err_underflow, 0);
    chk("uf_occ0", occupancy, 0);
    #1 chk("uf_ready", rsp_ready, 1);
    tick();
    rsp_valid = 0;
    chk("uf_no_en", rsp_entry_en, 0);
    chk("uf_err", err_underflow, 1);
    chk("uf_occ", occupancy, 0);
    req_valid = 1;
    tick();
    req_valid = 0;
    chk("uf_sticky", err_underflow, 1);
    chk("uf_occ1", occupancy, 1);
    req_valid = 1;
    tick();
    req_valid = 0;
    flush_req = 1;
    tick();
    flush_req = 0;
    rnp_valid = 1;
    tick();
    rnp_valid = 0;
    chk("ar_rnpv", read_no_snp_v, 1);
    chk("ar_occ2", occupancy, 2);
    #2 rst = 1;
    #1 chk("ar_occ", occupancy, 0);
    chk("ar_rnpv0", read_no_snp_v, 0);
    chk("ar_rnpdata", read_no_snp, 0);
    chk("ar_err", err_underflow, 0);
    chk("ar_done", flush_done, 0);
    #1 rst = 0;
    req_valid = 1;
    #1 chk("ar_run_req", req_ready, 1);
    tick();
    req_valid = 0;
    chk("ar_occ1", occupancy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
